// File: rtl/rv_isa_pkg.sv
// Shared RV32I/RV64I ISA constants: base opcodes and immediate-format encodings.
package rv_isa_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned FMT_W   = 3;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    // funct3 values of op-imm that select a shift-amount immediate
    localparam logic [2:0] F3_SLLI      = 3'b001;
    localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } imm_fmt_e;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate decode: opcode -> format, format -> sign-extended immediate.
module imm_decode_comb
    import rv_isa_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [INSTR_W-1:0] instr_i,
    output logic [FMT_W-1:0]   fmt_c,
    output logic [WIDTH-1:0]   imm_c
);

    imm_fmt_e    fmt;
    logic        s;
    logic [5:0]  shamt;
    logic [31:0] raw32;

    assign s = instr_i[31];

    always_comb begin
        fmt = FMT_NONE;
        unique case (instr_i[6:0])
            OPC_LOAD, OPC_JALR, OPC_FENCE, OPC_SYSTEM: fmt = FMT_I;
            OPC_OPIMM: begin
                if (instr_i[14:12] == F3_SLLI || instr_i[14:12] == F3_SRLI_SRAI) begin
                    fmt = FMT_SHAMT;
                end else begin
                    fmt = FMT_I;
                end
            end
            OPC_STORE:          fmt = FMT_S;
            OPC_BRANCH:         fmt = FMT_B;
            OPC_LUI, OPC_AUIPC: fmt = FMT_U;
            OPC_JAL:            fmt = FMT_J;
            default:            fmt = FMT_NONE;
        endcase
    end

    // RV64 shifts take a 6-bit amount; RV32 ignores instr[25] (part of funct7 there)
    always_comb begin
        shamt = 6'd0;
        if (WIDTH == 64) begin
            shamt = instr_i[25:20];
        end else begin
            shamt = {1'b0, instr_i[24:20]};
        end
    end

    // Build a 32-bit value already sign-extended; shamt stays positive so widening is uniform
    always_comb begin
        raw32 = 32'd0;
        unique case (fmt)
            FMT_I:     raw32 = {{20{s}}, instr_i[31:20]};
            FMT_S:     raw32 = {{20{s}}, instr_i[31:25], instr_i[11:7]};
            FMT_B:     raw32 = {{19{s}}, s, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U:     raw32 = {instr_i[31:12], 12'd0};
            FMT_J:     raw32 = {{11{s}}, s, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            FMT_SHAMT: raw32 = 32'(shamt);
            default:   raw32 = 32'd0;
        endcase
    end

    assign imm_c = WIDTH'($signed(raw32));
    assign fmt_c = fmt;

endmodule

// File: rtl/immediate_generator.sv
// ID-stage immediate generator: decoded immediate, format and valid flag registered at ID/EX.
module immediate_generator
    import rv_isa_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    output logic [WIDTH-1:0]   immediate,
    output logic [FMT_W-1:0]   imm_fmt,
    output logic               imm_valid
);

    logic [WIDTH-1:0] imm_c;
    logic [FMT_W-1:0] fmt_c;

    logic [WIDTH-1:0] imm_d,   imm_q;
    logic [FMT_W-1:0] fmt_d,   fmt_q;
    logic             valid_d, valid_q;

    imm_decode_comb #(
        .WIDTH (WIDTH)
    ) u_decode (
        .instr_i (instruction),
        .fmt_c   (fmt_c),
        .imm_c   (imm_c)
    );

    always_comb begin
        imm_d   = imm_c;
        fmt_d   = fmt_c;
        valid_d = (fmt_c != FMT_NONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imm_q   <= '0;
            fmt_q   <= FMT_NONE;
            valid_q <= 1'b0;
        end else begin
            imm_q   <= imm_d;
            fmt_q   <= fmt_d;
            valid_q <= valid_d;
        end
    end

    assign immediate = imm_q;
    assign imm_fmt   = fmt_q;
    assign imm_valid = valid_q;

endmodule

// File: tb/tb_immediate_generator.sv
// Directed bench for immediate_generator: RV32 and RV64 instances driven by the same stream.
module tb_immediate_generator;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        valid32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        valid64;

    int compared;
    int mismatched;

    localparam logic [2:0] F_NONE  = 3'd0;
    localparam logic [2:0] F_I     = 3'd1;
    localparam logic [2:0] F_S     = 3'd2;
    localparam logic [2:0] F_B     = 3'd3;
    localparam logic [2:0] F_U     = 3'd4;
    localparam logic [2:0] F_J     = 3'd5;
    localparam logic [2:0] F_SHAMT = 3'd6;

    immediate_generator #(.WIDTH(32)) dut32 (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .immediate   (imm32),
        .imm_fmt     (fmt32),
        .imm_valid   (valid32)
    );

    immediate_generator #(.WIDTH(64)) dut64 (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .immediate   (imm64),
        .imm_fmt     (fmt64),
        .imm_valid   (valid64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare both instances' outputs against hand-computed values
    task automatic expect_out(input string tag, input logic [31:0] e32, input logic [63:0] e64,
                              input logic [2:0] efmt);
        check({tag, " imm32"},   64'(imm32),   64'(e32));
        check({tag, " fmt32"},   64'(fmt32),   64'(efmt));
        check({tag, " valid32"}, 64'(valid32), 64'(efmt != F_NONE));
        check({tag, " imm64"},   imm64,        e64);
        check({tag, " fmt64"},   64'(fmt64),   64'(efmt));
        check({tag, " valid64"}, 64'(valid64), 64'(efmt != F_NONE));
    endtask

    // Drive at the falling edge, sample 1 time unit after the following rising edge
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] e32,
                        input logic [63:0] e64, input logic [2:0] efmt);
        @(negedge clk);
        instruction = ins;
        @(posedge clk);
        #1;
        expect_out(tag, e32, e64, efmt);
    endtask

    logic [31:0] s_ins [6];
    logic [31:0] s_e32 [6];
    logic [63:0] s_e64 [6];
    logic [2:0]  s_fmt [6];

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b1;
        instruction = 32'hFFF0_0093;

        // Reset holds outputs clear before any clock edge
        #3;
        expect_out("reset_t0", 32'h0, 64'h0, F_NONE);
        @(posedge clk);
        #1;
        expect_out("reset_edge", 32'h0, 64'h0, F_NONE);
        @(negedge clk);
        reset = 1'b0;

        step("addi_m1",  32'hFFF0_0093, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, F_I);
        step("sw_8",     32'h0020_A423, 32'h0000_0008, 64'h0000_0000_0000_0008, F_S);
        step("sw_m4",    32'hFE20_AE23, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, F_S);
        step("beq_m4",   32'hFE00_0EE3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, F_B);
        step("lui",      32'h1234_50B7, 32'h1234_5000, 64'h0000_0000_1234_5000, F_U);
        step("lui_neg",  32'h8000_00B7, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, F_U);
        step("jal_2048", 32'h0010_006F, 32'h0000_0800, 64'h0000_0000_0000_0800, F_J);
        step("jal_m4",   32'hFFDF_F06F, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, F_J);
        step("srli_31",  32'h01F0_D093, 32'h0000_001F, 64'h0000_0000_0000_001F, F_SHAMT);
        step("srli_63",  32'h03F0_D093, 32'h0000_001F, 64'h0000_0000_0000_003F, F_SHAMT);
        step("srai_5",   32'h4050_D093, 32'h0000_0005, 64'h0000_0000_0000_0005, F_SHAMT);
        step("slli_1",   32'h0010_9093, 32'h0000_0001, 64'h0000_0000_0000_0001, F_SHAMT);
        step("add",      32'h0020_81B3, 32'h0000_0000, 64'h0000_0000_0000_0000, F_NONE);
        step("fence",    32'h0000_000F, 32'h0000_0000, 64'h0000_0000_0000_0000, F_I);
        step("illegal",  32'hFFFF_FFFF, 32'h0000_0000, 64'h0000_0000_0000_0000, F_NONE);
        step("jalr_m8",  32'hFF80_80E7, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, F_I);

        // Back-to-back stream: output holds until the next edge, then moves exactly one step
        s_ins[0] = 32'hFFF0_0093; s_e32[0] = 32'hFFFF_FFFF; s_e64[0] = 64'hFFFF_FFFF_FFFF_FFFF; s_fmt[0] = F_I;
        s_ins[1] = 32'h0020_A423; s_e32[1] = 32'h0000_0008; s_e64[1] = 64'h8;                   s_fmt[1] = F_S;
        s_ins[2] = 32'hFE00_0EE3; s_e32[2] = 32'hFFFF_FFFC; s_e64[2] = 64'hFFFF_FFFF_FFFF_FFFC; s_fmt[2] = F_B;
        s_ins[3] = 32'h1234_50B7; s_e32[3] = 32'h1234_5000; s_e64[3] = 64'h1234_5000;           s_fmt[3] = F_U;
        s_ins[4] = 32'h002081B3;  s_e32[4] = 32'h0;         s_e64[4] = 64'h0;                   s_fmt[4] = F_NONE;
        s_ins[5] = 32'h0010_006F; s_e32[5] = 32'h0000_0800; s_e64[5] = 64'h800;                 s_fmt[5] = F_J;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                expect_out($sformatf("stream_hold%0d", i), s_e32[i-1], s_e64[i-1], s_fmt[i-1]);
            end
            instruction = s_ins[i];
            @(posedge clk);
            #1;
            expect_out($sformatf("stream%0d", i), s_e32[i], s_e64[i], s_fmt[i]);
        end

        // Asynchronous reset mid-stream clears outputs without a clock edge
        #1;
        reset = 1'b1;
        #1;
        expect_out("async_rst", 32'h0, 64'h0, F_NONE);
        @(negedge clk);
        instruction = 32'h0020_A423;
        @(posedge clk);
        #1;
        expect_out("rst_held", 32'h0, 64'h0, F_NONE);

        // First result after release is the instruction sampled at the first edge
        @(negedge clk);
        reset = 1'b0;
        instruction = 32'h01F0_D093;
        #1;
        expect_out("rst_released", 32'h0, 64'h0, F_NONE);
        @(posedge clk);
        #1;
        expect_out("resume", 32'h0000_001F, 64'h1F, F_SHAMT);
        step("resume2", 32'hFE00_0EE3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, F_B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
